// File: rtl/adder_subs_pkg.sv
// Shared types, constants and helpers for the adder/subtractor display block.
//   state_t     : conversion loop states (IDLE, LOAD, SHIFT, DONE)
//   SEG_BLANK   : all segments off (active-low)
//   SEG_MINUS   : only segment g lit
//   seg7_decode : BCD nibble -> active-low glyph, segm[0]=a .. segm[6]=g
package adder_subs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load bin, clear BCD and iteration counter
//   bin      : BIN_W-bit unsigned value
//   done     : high during the cycle that performs the final step
//   bcd      : BCD_DIGITS packed nibbles, valid the cycle after done
module bin2bcd_seq #(
    parameter int BIN_W      = 5,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    logic [BIN_W-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    // Adjusted nibbles without the top bit, which the shift would discard.
    logic [BCD_W-2:0] adj;

    function automatic logic [3:0] dabble(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            if (gi < BCD_DIGITS - 1) begin : g_full
                assign adj[4*gi +: 4] = dabble(bcd_reg[4*gi +: 4]);
            end else begin : g_top
                assign adj[4*gi +: 3] = 3'(dabble(bcd_reg[4*gi +: 4]));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            bin_reg  <= bin;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            bcd_reg <= {adj, bin_reg[BIN_W-1]};
            bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
            if (cnt_reg == LAST) begin
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign done = busy_reg && (cnt_reg == LAST);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/adder_subs_disp.sv
// Adds or subtracts two unsigned operands, converts the signed result to BCD
// and shows it on a multiplexed common-anode 7-segment display, sign on the
// leftmost digit. Computation loops continuously: LOAD, WIDTH+1 SHIFT, DONE.
//   clk, rst   : clock, asynchronous active-high reset
//   a, b       : WIDTH-bit unsigned operands, sampled only in LOAD
//   sum_rest   : 0 = a+b, 1 = a-b
//   segm       : active-low segments, segm[0]=a .. segm[6]=g
//   transistor : active-low one-hot digit enable, bit0 = rightmost digit
//   disp_upd   : one-cycle pulse when the display register reloads
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module adder_subs_disp
    import adder_subs_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sum_rest,
    output logic [6:0]        segm,
    output logic [DIGITS-1:0] transistor,
    output logic              disp_upd
);

    localparam int NUM_DIGITS = DIGITS - 1;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state_reg, state_next;
    logic              neg_reg;
    logic [BCD_W-1:0]  disp_bcd_reg;
    logic              disp_neg_reg;
    logic              disp_upd_reg;
    logic [PW-1:0]     presc_reg;
    logic [IW-1:0]     idx_reg;
    logic [6:0]        segm_reg, segm_next;
    logic [DIGITS-1:0] tr_reg, tr_next;

    logic [WIDTH:0]    a_ext, b_ext, mag_load;
    logic              a_lt_b, neg_load;
    logic              conv_start, conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [NUM_DIGITS-1:0][6:0] digit_glyph;

    // Magnitude/sign of the result; a zero difference is never negative.
    assign a_ext    = {1'b0, a};
    assign b_ext    = {1'b0, b};
    assign a_lt_b   = (a < b);
    assign mag_load = !sum_rest ? (a_ext + b_ext)
                    : (a_lt_b ? (b_ext - a_ext) : (a_ext - b_ext));
    assign neg_load = sum_rest && a_lt_b;

    assign conv_start = (state_reg == LOAD);

    bin2bcd_seq #(
        .BIN_W      (WIDTH + 1),
        .BCD_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag_load),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (conv_done) state_next = DONE;
            DONE:    state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            neg_reg      <= 1'b0;
            disp_bcd_reg <= '0;
            disp_neg_reg <= 1'b0;
            disp_upd_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            disp_upd_reg <= (state_reg == DONE);
            if (state_reg == LOAD) begin
                neg_reg <= neg_load;
            end
            // Display only reloads with a complete conversion.
            if (state_reg == DONE) begin
                disp_bcd_reg <= conv_bcd;
                disp_neg_reg <= neg_reg;
            end
        end
    end

    // Glyph per numeric digit; optionally blank zeros left of the first
    // non-zero digit, always keeping digit 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_units
                assign digit_glyph[gi] = seg7_decode(disp_bcd_reg[3:0]);
            end else begin : g_upper
                assign digit_glyph[gi] = (disp_bcd_reg[BCD_W-1:4*gi] == '0)
                                       ? SEG_BLANK
                                       : seg7_decode(disp_bcd_reg[4*gi +: 4]);
            end
`else
            assign digit_glyph[gi] = seg7_decode(disp_bcd_reg[4*gi +: 4]);
`endif
        end
    endgenerate

    always_comb begin
        tr_next   = '1;
        segm_next = SEG_BLANK;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_reg == IW'(k)) tr_next[k] = 1'b0;
        end
        if (idx_reg == IW'(DIGITS - 1)) begin
            segm_next = disp_neg_reg ? SEG_MINUS : SEG_BLANK;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_reg == IW'(k)) segm_next = digit_glyph[k];
            end
        end
    end

    // Segments and enables are both registered from idx_reg so they switch
    // on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            tr_reg    <= '1;
            segm_reg  <= SEG_BLANK;
        end else begin
            tr_reg   <= tr_next;
            segm_reg <= segm_next;
            if (presc_reg == PW'(REFRESH_DIV - 1)) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end

    assign segm       = segm_reg;
    assign transistor = tr_reg;
    assign disp_upd   = disp_upd_reg;

endmodule

// File: tb/tb_adder_subs_disp.sv
module tb_adder_subs_disp;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int RD = 4;

    typedef logic [D-1:0][6:0] disp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         op_in = 1'b0;
    logic [6:0]   segm;
    logic [D-1:0] transistor;
    logic         disp_upd;

    disp_t q[$];
    disp_t cur;
    bit    mon_en = 1'b0;
    bit    since_valid = 1'b0;
    int    since = 0;
    int    scan_cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    adder_subs_disp #(
        .WIDTH       (W),
        .DIGITS      (D),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a_in),
        .b          (b_in),
        .sum_rest   (op_in),
        .segm       (segm),
        .transistor (transistor),
        .disp_upd   (disp_upd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected glyphs for every digit position after computing (a op b).
    function automatic disp_t model(input int a, input int b, input int op);
        disp_t e;
        int res, d0, d1, d2;
        bit neg;
        if (op != 0) res = (a >= b) ? a - b : b - a;
        else         res = a + b;
        neg = (op != 0) && (a < b);
        d0 = res % 10;
        d1 = (res / 10) % 10;
        d2 = (res / 100) % 10;
        e[0] = glyph(d0);
        e[1] = glyph(d1);
        e[2] = glyph(d2);
        e[3] = neg ? 7'h3F : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 0) e[2] = 7'h7F;
        if (d2 == 0 && d1 == 0) e[1] = 7'h7F;
`endif
        return e;
    endfunction

    // Every cycle: scan position from elapsed cycles, segments against the
    // expected display; on disp_upd pop the next expected display.
    task automatic monitor();
        int dig;
        logic [D-1:0] exp_tr;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                dig = (scan_cyc / RD) % D;
                exp_tr = '1;
                exp_tr[dig] = 1'b0;
                check("scan_transistor", transistor, exp_tr);
                since++;
                if (disp_upd) begin
                    if (since_valid) check("upd_period", since, W + 3);
                    since = 0;
                    since_valid = 1'b1;
                    if (q.size() == 0) check("scoreboard_empty", 0, 1);
                    else cur = q.pop_front();
                end else begin
                    check($sformatf("segm_digit%0d", dig), segm, cur[dig]);
                end
                scan_cyc++;
            end
        end
    endtask

    // Returns at the negedge where disp_upd is high (the LOAD cycle).
    task automatic wait_upd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (disp_upd) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("upd_timeout", 0, 1);
    endtask

    task automatic apply(input int a, input int b, input int op, input int loops);
        wait_upd();
        a_in  = W'(a);
        b_in  = W'(b);
        op_in = op[0];
        q.push_back(model(a, b, op));
        for (int i = 1; i < loops; i++) begin
            wait_upd();
            q.push_back(model(a_in, b_in, op_in));
        end
        $display("op a=%0d b=%0d sub=%0d loops=%0d", a, b, op, loops);
    endtask

    task automatic do_reset();
        int cnt;
        bit found;
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_transistor", transistor, 4'hF);
        check("rst_segm", segm, 7'h7F);
        check("rst_disp_upd", disp_upd, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_transistor", transistor, 4'hF);
        check("rst_hold_segm", segm, 7'h7F);
        q.delete();
        q.push_back(model(a_in, b_in, op_in));
        cur = model(0, 0, 0);
        since_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        scan_cyc = 0;
        mon_en = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (disp_upd) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                cnt++;
            end
        end
        check("rst_to_first_upd", found ? cnt : 999, W + 3);
        q.push_back(model(a_in, b_in, op_in));
        $display("reset done, first disp_upd after %0d cycles", cnt);
    endtask

    initial begin
        fork
            monitor();
        join_none

        do_reset();

        apply(7, 5, 0, 4);     // 12
        apply(3, 9, 1, 4);     // -6
        apply(15, 15, 0, 4);   // 30, largest sum
        apply(9, 9, 1, 4);     // zero difference, no sign
        apply(0, 15, 1, 3);    // -15, largest negative
        apply(15, 0, 1, 3);    // 15
        apply(0, 0, 0, 3);     // all-zero result
        for (int i = 0; i < 4; i++) begin
            apply($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 3);
        end

        // Operand change during SHIFT only affects the following load.
        apply(2, 3, 0, 1);
        repeat (2) @(negedge clk);
        a_in = 4'd8;
        apply(8, 3, 0, 3);

        // Reset during SHIFT aborts the conversion; display returns to 0.
        apply(9, 4, 0, 1);
        repeat (3) @(negedge clk);
        do_reset();

        apply(12, 7, 1, 3);
        wait_upd();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_subs_disp.md
Name: adder_subs_disp

Overview:
Parametrised successor of the 4-bit adder/subtractor display block. It registers two WIDTH-bit unsigned operands and performs add or subtract. The signed result is converted to BCD by a sequential double-dabble engine. The result is shown on a DIGITS-wide multiplexed common-anode 7-segment display, with the sign on the leftmost digit. It sits between the board switches and the display pins.

Parameters:
WIDTH, 4, operand width in bits; result magnitude is WIDTH+1 bits.
DIGITS, 4, display digits; DIGITS-1 must hold the decimal digits of 2^(WIDTH+1)-2, and the leftmost digit is the sign.
REFRESH_DIV, 100000, clk cycles each digit is held during scan; must be ≥2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
sum_rest  in  1  0 = add (a+b), 1 = subtract (a-b)
segm  out  7  segments, active-low, segm[0]=a … segm[6]=g
transistor  out  DIGITS  digit enables, active-low one-hot, bit0 = rightmost digit
disp_upd  out  1  one-cycle pulse when the display register reloads

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; BCD shift register and display register are cleared to 0 with sign positive.
  - Prescaler and digit index are cleared to 0.
  - transistor = all ones; segm = 7'h7F; disp_upd = 0.
  - Outputs stay in this state while rst is high.
- FSM states:
  - IDLE -> LOAD unconditionally.
  - LOAD:
    - Capture a, b and sum_rest; inputs are not sampled at any other time.
    - Add: mag = a+b (WIDTH+1 bits), neg = 0.
    - Subtract with a≥b: mag = a-b, neg = 0.
    - Subtract with a<b: mag = b-a, neg = 1.
    - -> SHIFT with iteration counter = 0.
  - SHIFT:
    - One double-dabble step per cycle: add 3 to every BCD nibble ≥5, then shift left with the next mag MSB.
    - Runs WIDTH+1 cycles, then -> DONE.
  - DONE:
    - Copy BCD nibbles and neg into the display register; pulse disp_upd for 1 cycle.
    - -> LOAD, giving continuous recomputation.
- Latency: LOAD-sample to disp_upd is exactly WIDTH+2 cycles; one full loop is WIDTH+3 cycles.
- The display register changes only in DONE, so there is no partial-value flicker. Input changes during SHIFT take effect on the next LOAD.
- Zero result is never negative (a=b subtract gives neg=0).
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index increments modulo DIGITS, from DIGITS-1 back to 0.
  - transistor = ~(1<<index). segm is a registered decode of the selected digit, so segm and transistor change on the same edge.
- Digit content:
  - Digits 0..DIGITS-2 show BCD nibbles 0..DIGITS-2 as decimal glyphs.
  - Digit DIGITS-1 shows '-' (7'h3F) if neg, else blank (7'h7F).
  - BCD nibbles beyond the computed width read 0.
- Reset mid-operation aborts the conversion immediately. No stale value survives.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits 1..DIGITS-2 show blank (7'h7F) when they and all digits to their left (excluding the sign) are 0. Digit 0 is always shown. A '-' remains on the leftmost digit.
- Undefined: all numeric digits are shown, including leading '0' (7'h40).

Decomposition:
- Package adder_subs_pkg:
  - FSM state enum (IDLE, LOAD, SHIFT, DONE).
  - Constants SEG_BLANK=7'h7F and SEG_MINUS=7'h3F.
  - Function seg7_decode(nibble) -> active-low glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Sub-module bin2bcd_seq holds the double-dabble datapath and iteration counter, with start/done handshake. The top owns the operand capture, display register and scan.

Test Plan:
1. Reset: assert rst mid-run -> same cycle transistor=4'b1111 and segm=7'h7F. Release -> disp_upd after WIDTH+3 cycles; digit0 shows 7'h40.
2. a=7, b=5, add; REFRESH_DIV=4 -> display register 12 after disp_upd.
   - digit0 segm=7'h24, digit1 segm=7'h79, digit3 blank.
   - digit2: 7'h40, or 7'h7F with LEADING_ZERO_BLANK_EN.
3. a=3, b=9, subtract -> digit0=7'h02 ('6'), digit3=7'h3F ('-'), neg=1.
4. a=15, b=15, add -> 30: digit0=7'h40, digit1=7'h30. Then a=b=9, subtract -> 0 and sign blank.
5. Scan, REFRESH_DIV=4: transistor sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.
6. Change a during SHIFT -> the next disp_upd shows the old value and the following one shows the new value. An rst pulse during SHIFT -> display returns to 0.
